sdr_req_arbiter: RTL and testbench
==================================

# sdr_req_arbiter

Front-end scheduler for `sdr_ctrl_main`. It shares the single SDRAM command path between up to `NUM_REQ` requesters and a built-in auto-refresh timer. It drives the controller's `penable`/`pwrite` access strobe and its refresh request, and tracks completion via the controller's cycle-end and refresh-acknowledge signals. Refreshes are postponed behind traffic up to a bound, then forced.

## Interface

Parameters:
- `NUM_REQ`, default 4, number of requesters (2..8).
- `REF_INTERVAL`, default 780, clocks between refresh ticks (≥2).
- `MAX_POSTPONE`, default 8, pending-refresh limit (1..15).

Ports:
- `pclk`  in  1  system clock; all logic on rising edge.
- `preset`  in  1  reset, asynchronous, active-high.
- `init_done`  in  1  controller initialisation complete; gates timer and arbitration.
- `req`  in  NUM_REQ  per-requester access request, level.
- `req_write`  in  NUM_REQ  per-requester direction (1 = write); valid while `req` is high.
- `gnt`  out  NUM_REQ  one-hot grant; all-zero when no grant is active.
- `ctrl_penable`  out  1  access strobe to controller.
- `ctrl_pwrite`  out  1  direction to controller.
- `ctrl_ref_req`  out  1  refresh request to controller.
- `ctrl_ref_ack`  in  1  refresh acknowledge from controller.
- `ctrl_cyc_end`  in  1  controller cycle-end (high when the controller is idle or finishing).
- `ref_pending`  out  4  outstanding refresh count.
- `ref_overflow`  out  1  sticky: a refresh tick arrived while `ref_pending == MAX_POSTPONE`.

## Operation

- Refresh timer:
  - Counts 0..REF_INTERVAL-1 only while `init_done` is high, then wraps to 0.
  - On wrap it generates a tick, and `ref_pending` increments, saturating at `MAX_POSTPONE`.
  - A tick at saturation sets `ref_overflow`. The flag clears only on reset.
- Scheduler FSM states:
  - **IDLE**: no output asserted. Acts only if `init_done` is high.
    - If `ref_pending == MAX_POSTPONE`, or (`ref_pending > 0` and `req == 0`), go to REF.
    - Otherwise, if `req != 0`, select a winner, register `gnt`, and go to ACCESS.
  - **ACCESS**:
    - `ctrl_penable = 1`; `ctrl_pwrite = req_write[winner]`.
    - When `ctrl_cyc_end == 0` (command accepted), drop `ctrl_penable` and go to BUSY.
  - **BUSY**: when `ctrl_cyc_end == 1`, clear `gnt` and go to IDLE.
  - **REF**: `ctrl_ref_req = 1`. When `ctrl_ref_ack == 1`, drop the request and go to REF_WAIT.
  - **REF_WAIT**: when `ctrl_ref_ack == 0`, decrement `ref_pending` and go to IDLE.
- Winner selection is set by `SDR_ARB_RR_EN` (see Configuration).
- A requester must hold `req` and `req_write` stable while its `gnt` is high. Dropping `req` mid-grant is ignored: the cycle completes.
- Simultaneous timer tick and decrement: `ref_pending` is unchanged. A tick at saturation together with a decrement still leaves `ref_pending == MAX_POSTPONE` and does not set `ref_overflow`.
- `init_done` falling: the timer freezes, and the FSM finishes its current state sequence, then holds in IDLE.

## Timing

- Reset values:
  - `gnt = 0`, `ctrl_penable = 0`, `ctrl_pwrite = 0`, `ctrl_ref_req = 0`, `ref_pending = 0`, `ref_overflow = 0`.
  - Timer = 0, FSM = IDLE, RR pointer = NUM_REQ-1 (so requester 0 wins first).
- All outputs are registered.
- Request latency: `req` sampled high in IDLE at edge k gives `gnt` and `ctrl_penable` high from edge k (visible in cycle k+1).
- Refresh latency: a tick at edge k while IDLE with no requests gives `ctrl_ref_req` high after edge k+1.
- Minimum access occupancy is 3 cycles (IDLE→ACCESS→BUSY→IDLE). `gnt` stays high through ACCESS and BUSY.
- Back-to-back grants: at least one IDLE cycle separates consecutive grants.
- Reset asserted mid-operation: all outputs return to reset values asynchronously. Any pending refresh count is lost.

## Configuration

- `SDR_ARB_RR_EN` defined: round-robin arbitration.
  - Search starts at pointer+1, modulo NUM_REQ.
  - The pointer updates to the winner on each grant.
- `SDR_ARB_RR_EN` undefined: fixed priority, lowest index wins. No pointer register exists.

## Test plan

- Reset then `init_done=1` with `req=4'b0001`, `req_write=0`: `gnt=0001` and `ctrl_penable=1`, `ctrl_pwrite=0` on the next cycle. `ctrl_cyc_end` 1→0→1 returns the FSM to IDLE and `gnt=0`.
- With RR enabled, hold `req=4'b1111` for four accesses: grants go 0,1,2,3. With RR disabled, every grant goes to requester 0.
- `REF_INTERVAL=20`, no requests: `ctrl_ref_req` rises one cycle after the tick. An ack pulse returns `ref_pending` 1→0.
- `REF_INTERVAL=20`, `MAX_POSTPONE=2`, continuous `req`:
  - Refresh is deferred until `ref_pending==2`, then forced ahead of the waiting request.
  - A third tick before service sets `ref_overflow`, and it stays set.
- Assert `preset` during BUSY and again during REF: `gnt`, `ctrl_ref_req` and `ref_pending` go to 0 immediately. The FSM restarts cleanly after release.
- `init_done=0` with `req=1111`: no grant and no tick for 100 cycles.

Source files
------------

// File: rtl/sdr_req_arbiter_if.sv
// sdr_req_arbiter_if: requester, controller and status signals
// master = arbiter side, slave = requesters/controller side
interface sdr_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic               init_done;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_write;
  logic [NUM_REQ-1:0] gnt;
  logic               ctrl_penable;
  logic               ctrl_pwrite;
  logic               ctrl_ref_req;
  logic               ctrl_ref_ack;
  logic               ctrl_cyc_end;
  logic [3:0]         ref_pending;
  logic               ref_overflow;

  modport master (
    input  init_done, req, req_write,
    input  ctrl_ref_ack, ctrl_cyc_end,
    output gnt, ctrl_penable, ctrl_pwrite,
    output ctrl_ref_req, ref_pending,
    output ref_overflow
  );

  modport slave (
    output init_done, req, req_write,
    output ctrl_ref_ack, ctrl_cyc_end,
    input  gnt, ctrl_penable, ctrl_pwrite,
    input  ctrl_ref_req, ref_pending,
    input  ref_overflow
  );
endinterface

// File: rtl/sdr_req_arbiter.sv
// sdr_req_arbiter: shares the SDRAM command path and schedules refresh
// Define SDR_ARB_RR_EN for round-robin, else fixed lowest-index priority
module sdr_req_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int REF_INTERVAL = 780,
  parameter int MAX_POSTPONE = 8
) (
  input  logic pclk,
  input  logic preset,
  sdr_req_arbiter_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [3:0] MAXP = 4'(MAX_POSTPONE);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  localparam logic [TW-1:0] TLAST = TW'(REF_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_BUSY,
    S_REF,
    S_REF_WAIT
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               pen_q;
  logic               pw_q;
  logic               rreq_q;
  logic [3:0]         pend_q;
  logic               ovf_q;
  logic [TW-1:0]      tmr_q;
  logic               tick;
  logic               dec;
  logic               win_found;
  logic [IW-1:0]      win_idx;
`ifdef SDR_ARB_RR_EN
  logic [IW-1:0]      ptr_q;
`endif

  assign tick = bus.init_done && (tmr_q == TLAST);
  assign dec  = (state_q == S_REF_WAIT) && !bus.ctrl_ref_ack;

  assign bus.gnt          = gnt_q;
  assign bus.ctrl_penable = pen_q;
  assign bus.ctrl_pwrite  = pw_q;
  assign bus.ctrl_ref_req = rreq_q;
  assign bus.ref_pending  = pend_q;
  assign bus.ref_overflow = ovf_q;

  // Refresh interval timer, frozen while init is incomplete
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tmr_q <= '0;
    end else if (bus.init_done) begin
      tmr_q <= tick ? '0 : tmr_q + 1'b1;
    end
  end

  // Pending-refresh counter; tick and service in one cycle cancel out
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else if (tick && !dec) begin
      if (pend_q == MAXP) begin
        ovf_q <= 1'b1;
      end else begin
        pend_q <= pend_q + 1'b1;
      end
    end else if (dec && !tick) begin
      pend_q <= pend_q - 1'b1;
    end
  end

  // Winner selection among active requests
  always_comb begin
    win_found = |bus.req;
    win_idx   = '0;
`ifdef SDR_ARB_RR_EN
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (bus.req[(int'(ptr_q) + i) % NUM_REQ]) begin
        win_idx = IW'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
`else
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_idx = IW'(i);
      end
    end
`endif
  end

  // Scheduler: grant accesses, force refresh at the postpone limit
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      pen_q   <= 1'b0;
      pw_q    <= 1'b0;
      rreq_q  <= 1'b0;
`ifdef SDR_ARB_RR_EN
      ptr_q   <= IW'(NUM_REQ - 1);
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.init_done) begin
            if (pend_q == MAXP ||
                (pend_q != '0 && !win_found)) begin
              rreq_q  <= 1'b1;
              state_q <= S_REF;
            end else if (win_found) begin
              gnt_q   <= ONE << win_idx;
              pen_q   <= 1'b1;
              pw_q    <= bus.req_write[win_idx];
              state_q <= S_ACCESS;
`ifdef SDR_ARB_RR_EN
              ptr_q   <= win_idx;
`endif
            end
          end
        end
        S_ACCESS: begin
          if (!bus.ctrl_cyc_end) begin
            pen_q   <= 1'b0;
            pw_q    <= 1'b0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.ctrl_cyc_end) begin
            gnt_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        S_REF: begin
          if (bus.ctrl_ref_ack) begin
            rreq_q  <= 1'b0;
            state_q <= S_REF_WAIT;
          end
        end
        S_REF_WAIT: begin
          if (!bus.ctrl_ref_ack) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdr_req_arbiter.sv
// tb_sdr_req_arbiter: random requests and controller responses
// against a transaction-level reference model
module tb_sdr_req_arbiter;
  localparam int N  = 4;
  localparam int RI = 20;
  localparam int MP = 2;

  localparam int P_IDLE = 0;
  localparam int P_ACC  = 1;
  localparam int P_BUSY = 2;
  localparam int P_REF  = 3;
  localparam int P_RW   = 4;

  logic pclk = 1'b0;
  logic preset = 1'b1;

  sdr_req_arbiter_if #(.NUM_REQ(N)) bus();

  sdr_req_arbiter #(
    .NUM_REQ(N),
    .REF_INTERVAL(RI),
    .MAX_POSTPONE(MP)
  ) dut (
    .pclk(pclk),
    .preset(preset),
    .bus(bus)
  );

  always #5 pclk = ~pclk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  int m_ph, m_pend, m_en, m_last;
  int m_gnt, m_pen, m_pw, m_rr, m_ovf;

  task automatic model_reset();
    m_ph = P_IDLE; m_pend = 0; m_en = 0;
    m_last = N - 1;
    m_gnt = 0; m_pen = 0; m_pw = 0;
    m_rr = 0; m_ovf = 0;
  endtask

  function automatic int pick(int r);
`ifdef SDR_ARB_RR_EN
    for (int i = 1; i <= N; i++) begin
      int j;
      j = (m_last + i) % N;
      if (r[j]) return j;
    end
`else
    for (int i = 0; i < N; i++)
      if (r[i]) return i;
`endif
    return 0;
  endfunction

  task automatic model_step(bit init, int r, int rw,
                            bit ack, bit cyc);
    bit tick, served;
    int w, old;
    old = m_pend;
    served = (m_ph == P_RW) && !ack;
    tick = 0;
    if (init) begin
      m_en++;
      tick = (m_en % RI) == 0;
    end
    case (m_ph)
      P_IDLE: if (init) begin
        if (old == MP || (old > 0 && r == 0)) begin
          m_rr = 1; m_ph = P_REF;
        end else if (r != 0) begin
          w = pick(r);
          m_last = w;
          m_gnt = 1 << w;
          m_pen = 1;
          m_pw = (rw >> w) & 1;
          m_ph = P_ACC;
        end
      end
      P_ACC: if (!cyc) begin
        m_pen = 0; m_pw = 0; m_ph = P_BUSY;
      end
      P_BUSY: if (cyc) begin
        m_gnt = 0; m_ph = P_IDLE;
      end
      P_REF: if (ack) begin
        m_rr = 0; m_ph = P_RW;
      end
      default: if (!ack) m_ph = P_IDLE;
    endcase
    if (tick && !served) begin
      if (m_pend == MP) m_ovf = 1;
      else m_pend++;
    end else if (served && !tick) begin
      m_pend--;
    end
  endtask

  task automatic check_all();
    check("gnt", int'(bus.gnt), m_gnt);
    check("penable", int'(bus.ctrl_penable), m_pen);
    check("pwrite", int'(bus.ctrl_pwrite), m_pw);
    check("ref_req", int'(bus.ctrl_ref_req), m_rr);
    check("ref_pending", int'(bus.ref_pending), m_pend);
    check("ref_overflow", int'(bus.ref_overflow), m_ovf);
  endtask

  int acc_dly, acc_low, ref_dly, ref_hi;
  bit hit_busy, hit_ref;

  task automatic ctrl_reset();
    bus.ctrl_cyc_end = 1'b1;
    bus.ctrl_ref_ack = 1'b0;
    acc_dly = 0; acc_low = 0;
    ref_dly = 0; ref_hi = 0;
  endtask

  initial begin
    bit ovf_ph, init_ph;
    int nr, nw;
    bus.init_done = 1'b0;
    bus.req = '0;
    bus.req_write = '0;
    ctrl_reset();
    model_reset();
    hit_busy = 0;
    hit_ref = 0;
    repeat (2) @(negedge pclk);
    check_all();
    preset = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge pclk);
      if (preset) preset = 1'b0;
      check_all();
      ovf_ph  = (cyc >= 1200 && cyc < 1500);
      init_ph = (cyc >= 1000 && cyc < 1100);
      if ((cyc > 300 && !hit_busy && m_ph == P_BUSY) ||
          (cyc > 600 && !hit_ref && m_ph == P_REF)) begin
        if (m_ph == P_BUSY) hit_busy = 1;
        else hit_ref = 1;
        preset = 1'b1;
        #1;
        check("rst_gnt", int'(bus.gnt), 0);
        check("rst_ref_req", int'(bus.ctrl_ref_req), 0);
        check("rst_pending", int'(bus.ref_pending), 0);
        check("rst_penable", int'(bus.ctrl_penable), 0);
        model_reset();
        ctrl_reset();
      end
      if (bus.ctrl_cyc_end) begin
        if (bus.ctrl_penable) begin
          if (acc_dly > 0) acc_dly--;
          else begin
            bus.ctrl_cyc_end = 1'b0;
            acc_low = $urandom_range(1, 3);
          end
        end else begin
          acc_dly = $urandom_range(0, 2);
        end
      end else begin
        acc_low--;
        if (acc_low <= 0) bus.ctrl_cyc_end = 1'b1;
      end
      if (!bus.ctrl_ref_ack) begin
        if (bus.ctrl_ref_req) begin
          if (ref_dly > 0) ref_dly--;
          else begin
            bus.ctrl_ref_ack = 1'b1;
            ref_hi = $urandom_range(1, 2);
          end
        end else begin
          ref_dly = ovf_ph ? 45 : $urandom_range(0, 3);
        end
      end else begin
        ref_hi--;
        if (ref_hi <= 0) bus.ctrl_ref_ack = 1'b0;
      end
      if (init_ph) begin
        bus.init_done = 1'b0;
        nr = 15;
      end else begin
        bus.init_done = ($urandom_range(0, 99) != 0);
        if (ovf_ph) nr = 15;
        else if ($urandom_range(0, 1) == 1) nr = $urandom_range(1, 15);
        else nr = 0;
      end
      nw = $urandom_range(0, 15);
      nw = (nw & ~m_gnt) | (int'(bus.req_write) & m_gnt);
      bus.req = N'(nr);
      bus.req_write = N'(nw);
      if (!preset)
        model_step(bus.init_done, nr, nw,
                   bus.ctrl_ref_ack, bus.ctrl_cyc_end);
    end
    @(negedge pclk);
    check_all();
    check("ovf_sticky", int'(bus.ref_overflow), 1);
    check("rst_in_busy", int'(hit_busy), 1);
    check("rst_in_ref", int'(hit_ref), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
